if_id_register: RTL
===================

IF_ID_REGISTER -- requirements
Module: if_id_register

Interface
REQ-001 Parameter NOP_INSTR, default 32'h0000_0000, is the instruction word inserted as a bubble.
REQ-002 Clk  input  1  rising-edge clock for all state.
REQ-003 Reset  input  1  synchronous reset, active-low (0 = reset), sampled on Clk rising edge.
REQ-004 IF_PCadd4  input  32  PC+4 from Program_Counter.
REQ-005 IF_Instruction  input  32  instruction word fetched at currAddress.
REQ-006 IFIDWre_from_Load_use_Detection_Unit  input  1  1 = load new, 0 = hold (load-use stall).
REQ-007 PCWre_from_Control_Unit  input  1  0 = halt decoded; fetch stops.
REQ-008 Flush  input  1  1 = discard fetched instruction (taken branch in MEM or jump in ID).
REQ-009 ID_PCadd4  output  32  registered PC+4 to ID stage.
REQ-010 ID_Instruction  output  32  registered instruction to ID stage.
REQ-011 ID_Valid  output  1  1 = ID_Instruction is a real instruction, 0 = bubble.
REQ-012 ID_Halted  output  1  1 = block is in HALT state.

Function
REQ-013 Block SHALL implement a 3-state FSM: RUN, STALL, HALT; all outputs registered.
REQ-014 RUN, Flush=1: next cycle ID_Instruction=NOP_INSTR, ID_PCadd4=0, ID_Valid=0, state RUN.
REQ-015 RUN, Flush=0, IFIDWre=1, PCWre=1: capture IF_PCadd4/IF_Instruction, ID_Valid=1, state RUN; latency exactly 1 cycle.
REQ-016 RUN, Flush=0, IFIDWre=0: all data outputs and ID_Valid hold, state STALL.
REQ-017 STALL, IFIDWre=0, Flush=0: hold, remain STALL (no limit on stall length).
REQ-018 STALL, IFIDWre=1, Flush=0: capture inputs as REQ-015, state RUN.
REQ-019 Flush SHALL take priority over stall: STALL or RUN with Flush=1 and IFIDWre=0 -> bubble loaded, state RUN.
REQ-020 RUN, PCWre=0, Flush=0, IFIDWre=1: capture inputs once (the halt instruction passes to ID), state HALT.
REQ-021 PCWre=0 with IFIDWre=0 SHALL be treated as stall; halt taken only on a cycle with IFIDWre=1.
REQ-022 Flush=1 with PCWre=0 in same cycle: bubble loaded, state RUN (halt from wrong path discarded).
REQ-023 HALT: ID_Instruction=NOP_INSTR, ID_Valid=0 from first HALT cycle, ID_PCadd4 holds, ID_Halted=1; all inputs ignored; exit only by Reset.
REQ-024 ID_Halted SHALL be 0 in RUN and STALL.

Reset
REQ-025 Reset=0 at a Clk edge SHALL, regardless of state or other inputs, set state RUN, ID_PCadd4=0, ID_Instruction=NOP_INSTR, ID_Valid=0, ID_Halted=0, counters 0.
REQ-026 Reset asserted mid-STALL or in HALT SHALL abort it; first edge with Reset=1 follows REQ-014..REQ-022 from RUN.

Configuration
REQ-027 Macro IF_ID_PERF_CNT_EN, when defined, adds outputs Stall_Count (16) and Flush_Count (16).
REQ-028 With IF_ID_PERF_CNT_EN: Stall_Count +1 per cycle ending in STALL; Flush_Count +1 per edge where a bubble is loaded by Flush; both saturate at 16'hFFFF; frozen in HALT; cleared by Reset.
REQ-029 Without IF_ID_PERF_CNT_EN: ports and counter logic absent; all other behaviour identical.

Verification
REQ-030 Reset=0 one edge, then Reset=1, IF_PCadd4=4, IF_Instruction=32'h2001_0008, IFIDWre=1, PCWre=1 -> after edge 1 ID_PCadd4=4, ID_Instruction=32'h2001_0008, ID_Valid=1.
REQ-031 Loaded PCadd4=8; IFIDWre=0 for 3 edges while IF_PCadd4=12 -> outputs hold 8, state STALL, Stall_Count=3 (if enabled); IFIDWre=1 -> ID_PCadd4=12.
REQ-032 STALL with Flush=1, IFIDWre=0 -> ID_Instruction=NOP_INSTR, ID_Valid=0, state RUN, Flush_Count=1 (if enabled).
REQ-033 PCWre=0, IF_Instruction=32'hFC00_0000, IFIDWre=1 -> next edge ID_Instruction=32'hFC00_0000, ID_Halted=1; following edge ID_Valid=0; further Flush/inputs no effect; Reset=0 -> ID_Halted=0.
REQ-034 Same-cycle PCWre=0 and Flush=1 -> bubble, ID_Halted stays 0, state RUN.
REQ-035 Reset=0 during STALL with IFIDWre=0 -> all outputs to reset values next edge.

Source files
------------

// File: rtl/if_id_register.sv
// IF/ID pipeline register with RUN/STALL/HALT control and bubble insertion.
// Latency: one cycle from IF inputs to registered ID outputs.
// Backpressure: IFIDWre=0 holds the register (stall); Flush overrides stall; HALT holds until reset.
// Optional build macro: IF_ID_PERF_CNT_EN adds Stall_Count / Flush_Count outputs.
module if_id_register #(
  parameter logic [31:0] NOP_INSTR = 32'h0000_0000
) (
  input  logic        Clk,
  input  logic        Reset,
  input  logic [31:0] IF_PCadd4,
  input  logic [31:0] IF_Instruction,
  input  logic        IFIDWre_from_Load_use_Detection_Unit,
  input  logic        PCWre_from_Control_Unit,
  input  logic        Flush,
  output logic [31:0] ID_PCadd4,
  output logic [31:0] ID_Instruction,
  output logic        ID_Valid,
  output logic        ID_Halted
`ifdef IF_ID_PERF_CNT_EN
  ,
  output logic [15:0] Stall_Count,
  output logic [15:0] Flush_Count
`endif
);

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_HALT  = 2'd2
  } state_t;

  state_t state_q;
  state_t state_d;

  // Short local names for the long control inputs.
  logic load_en;
  logic pc_wre;
  assign load_en = IFIDWre_from_Load_use_Detection_Unit;
  assign pc_wre  = PCWre_from_Control_Unit;

  // Next values of the registered outputs.
  logic [31:0] pc_d;
  logic [31:0] instr_d;
  logic        valid_d;
  logic        halted_d;

  // A flush only counts as a bubble load while the block is still live.
  logic flush_bubble;
  assign flush_bubble = Flush && (state_q != ST_HALT);

  // State register: synchronous active-low reset always returns to RUN.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= ST_RUN;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic: flush beats stall beats halt; halt only on a loading cycle.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_RUN, ST_STALL: begin
        if (Flush) begin
          state_d = ST_RUN;
        end else if (!load_en) begin
          state_d = ST_STALL;
        end else if (!pc_wre) begin
          state_d = ST_HALT;
        end else begin
          state_d = ST_RUN;
        end
      end
      ST_HALT: begin
        state_d = ST_HALT;
      end
      default: begin
        state_d = ST_RUN;
      end
    endcase
  end

  // Output logic: compute what the ID-side registers take on the next edge.
  always_comb begin
    pc_d     = ID_PCadd4;
    instr_d  = ID_Instruction;
    valid_d  = ID_Valid;
    halted_d = (state_d == ST_HALT);
    case (state_q)
      ST_HALT: begin
        // The halt instruction has already passed to ID; from here on
        // only bubbles are presented and the PC value is frozen.
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
      ST_RUN, ST_STALL: begin
        if (Flush) begin
          pc_d    = 32'd0;
          instr_d = NOP_INSTR;
          valid_d = 1'b0;
        end else if (load_en) begin
          // Covers normal capture and the single capture of a halt instruction.
          pc_d    = IF_PCadd4;
          instr_d = IF_Instruction;
          valid_d = 1'b1;
        end
        // load_en=0 without flush: hold everything (stall).
      end
      default: begin
        pc_d    = 32'd0;
        instr_d = NOP_INSTR;
        valid_d = 1'b0;
      end
    endcase
  end

  // Output registers: every ID-side output comes straight from a flop.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      ID_PCadd4      <= 32'd0;
      ID_Instruction <= NOP_INSTR;
      ID_Valid       <= 1'b0;
      ID_Halted      <= 1'b0;
    end else begin
      ID_PCadd4      <= pc_d;
      ID_Instruction <= instr_d;
      ID_Valid       <= valid_d;
      ID_Halted      <= halted_d;
    end
  end

`ifdef IF_ID_PERF_CNT_EN
  // Saturating event counters; frozen once halted, cleared by reset.
  always_ff @(posedge Clk) begin
    if (!Reset) begin
      Stall_Count <= 16'd0;
      Flush_Count <= 16'd0;
    end else if (state_q != ST_HALT) begin
      if ((state_d == ST_STALL) && (Stall_Count != 16'hFFFF)) begin
        Stall_Count <= Stall_Count + 16'd1;
      end
      if (flush_bubble && (Flush_Count != 16'hFFFF)) begin
        Flush_Count <= Flush_Count + 16'd1;
      end
    end
  end
`else
  // Without counters the flush qualifier has no consumer.
  logic unused_flush_bubble;
  assign unused_flush_bubble = flush_bubble;
`endif

endmodule
